// File: rtl/add_proto_pkg.sv
// Shared codes for the two-phase operand protocol (p / p_seq / res_valid / s).
// Used by the request driver and by every adder FSM on the consumer side.
package add_proto_pkg;

    localparam int ADD_DATA_W = 4;

    localparam logic [1:0] P_SEQ_IDLE = 2'd0;
    localparam logic [1:0] P_SEQ_OP1  = 2'd1;
    localparam logic [1:0] P_SEQ_OP2  = 2'd2;

    typedef enum logic [2:0] {
        DRV_IDLE     = 3'd0,
        DRV_SEND_A   = 3'd1,
        DRV_GAP      = 3'd2,
        DRV_SEND_B   = 3'd3,
        DRV_WAIT_RES = 3'd4,
        DRV_RESP     = 3'd5
    } drv_state_t;

    // Counter width able to hold the larger of the two phase lengths.
    function automatic int cnt_width(input int gap_cyc, input int timeout_cyc);
        int m;
        m = (gap_cyc > timeout_cyc) ? gap_cyc : timeout_cyc;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/add_drv_cnt.sv
// Down-counter shared by the GAP and timeout phases of add_req_driver.
// load has priority over dec; dec stops at zero.
module add_drv_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/add_req_driver.sv
// Initiator for the two-phase operand protocol: request port -> p/p_seq -> s -> response port.
// ADD_DRV_TIMEOUT_EN enables the WAIT_RES timeout (rsp_err=1, rsp_sum=0 on expiry).
//
// state    | meaning
// IDLE     | req_ready=1, waiting for an operand pair
// SEND_A   | one cycle p_seq=1, p=a
// GAP      | GAP_CYC cycles p_seq=0, p held at a
// SEND_B   | one cycle p_seq=2, p=b; same-cycle res_valid is taken
// WAIT_RES | waiting for res_valid (or timeout)
// RESP     | rsp_valid=1 until rsp_ready
module add_req_driver
    import add_proto_pkg::*;
#(
    parameter int DATA_W      = ADD_DATA_W,
    parameter int GAP_CYC     = 0,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] p,
    output logic [1:0]        p_seq,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_err
);

    localparam int CNT_W = cnt_width(GAP_CYC, TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

    drv_state_t        state, next_state;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] p_nxt, rsp_sum_nxt;
    logic [1:0]        p_seq_nxt;
    logic              res_take, timed_out;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;

    assign res_take = ((state == DRV_SEND_B) || (state == DRV_WAIT_RES)) && res_valid;

`ifdef ADD_DRV_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    assign timed_out = (state == DRV_WAIT_RES) && cnt_zero && !res_valid;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = GAP_LOAD;
        if (state == DRV_SEND_A) cnt_load = 1'b1;
        if (state == DRV_GAP)    cnt_dec  = 1'b1;
`ifdef ADD_DRV_TIMEOUT_EN
        if (state == DRV_SEND_B) begin
            cnt_load = 1'b1;
            cnt_val  = TO_LOAD;
        end
        if (state == DRV_WAIT_RES) cnt_dec = 1'b1;
`endif
    end

    add_drv_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DRV_IDLE;
            p         <= '0;
            p_seq     <= P_SEQ_IDLE;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            state     <= next_state;
            p         <= p_nxt;
            p_seq     <= p_seq_nxt;
            rsp_valid <= (next_state == DRV_RESP);
            rsp_sum   <= rsp_sum_nxt;
            if ((state == DRV_IDLE) && req_valid) begin
                op_a <= req_a;
                op_b <= req_b;
            end
        end
    end

`ifdef ADD_DRV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst)            rsp_err <= 1'b0;
        else if (res_take)  rsp_err <= 1'b0;
        else if (timed_out) rsp_err <= 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            DRV_IDLE:     if (req_valid) next_state = DRV_SEND_A;
            DRV_SEND_A:   next_state = (GAP_CYC > 0) ? DRV_GAP : DRV_SEND_B;
            DRV_GAP:      if (cnt_zero) next_state = DRV_SEND_B;
            DRV_SEND_B:   next_state = res_valid ? DRV_RESP : DRV_WAIT_RES;
            DRV_WAIT_RES: if (res_valid || timed_out) next_state = DRV_RESP;
            DRV_RESP:     if (rsp_ready) next_state = DRV_IDLE;
            default:      next_state = DRV_IDLE;
        endcase
    end

    // Registered outputs are computed from next_state so they align with the state register.
    always_comb begin
        req_ready   = (state == DRV_IDLE);
        p_nxt       = '0;
        p_seq_nxt   = P_SEQ_IDLE;
        rsp_sum_nxt = rsp_sum;
        case (next_state)
            DRV_SEND_A: begin
                p_nxt     = req_a;
                p_seq_nxt = P_SEQ_OP1;
            end
            DRV_GAP:    p_nxt = op_a;
            DRV_SEND_B: begin
                p_nxt     = op_b;
                p_seq_nxt = P_SEQ_OP2;
            end
            default:    p_nxt = '0;
        endcase
        if (res_take)       rsp_sum_nxt = s;
        else if (timed_out) rsp_sum_nxt = '0;
    end

endmodule
